// File: rtl/mem_pkg.sv
// Shared encodings for the RAM sequencer/arbiter: phase states, port selects
// and the word-address mask helper.
package mem_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Identifies which port held the most recent grant.
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

    // Keep only the low logd bits of a word address; upper bits read as zero.
    function automatic logic [31:0] mask_addr(input logic [31:0] a, input int logd);
        logic [31:0] m;
        m = (logd >= 32) ? '1 : ((32'd1 << logd) - 32'd1);
        return a & m;
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot-phase byte assembler: packs four UART bytes little-endian into a word
// and issues one registered RAM write per word at consecutive addresses.
module boot_loader
    import mem_pkg::*;
#(
    parameter int LOGD       = 10,
    parameter int BOOT_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        done
);

    localparam logic [LOGD-1:0] LAST_WORD = LOGD'(BOOT_WORDS - 1);

    logic [1:0]      byte_cnt;
    logic [LOGD-1:0] word_cnt;
    logic [23:0]     held;

    // Byte 0 ends up in held[7:0] after three shifts, so the 4th byte lands on top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            held     <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            done     <= 1'b0;
            if (en && rx_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    wr_valid <= 1'b1;
                    wr_data  <= {rx_data, held};
                    wr_addr  <= {{(32-LOGD){1'b0}}, word_cnt};
                    word_cnt <= word_cnt + 1'b1;
                    done     <= (word_cnt == LAST_WORD);
                end else begin
                    held <= {rx_data, held[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// RAM sequencer: downloads the boot image over UART while the CPU is held in
// reset, then round-robins the single RAM port between fetch and data ports.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int LOGD       = 10,
    parameter int BOOT_WORDS = 256
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cpu_reset,
    output logic        boot_done,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_valid
);

    state_t      state;
    logic        run;
    logic        rr_last;
    logic        bl_wr_valid;
    logic [31:0] bl_wr_addr;
    logic [31:0] bl_wr_data;
    logic        bl_done;

    assign run       = (state == ST_RUN);
    assign cpu_reset = !run;
    assign boot_done = run;

    boot_loader #(.LOGD(LOGD), .BOOT_WORDS(BOOT_WORDS)) u_boot (
        .clk      (clk),
        .rst_n    (i_reset_n),
        .en       (!run),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .wr_valid (bl_wr_valid),
        .wr_addr  (bl_wr_addr),
        .wr_data  (bl_wr_data),
        .done     (bl_done)
    );

    // Phase register: leaves BOOT the cycle after the last boot write is issued.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)              state <= ST_BOOT;
        else if (!run && bl_done)    state <= ST_RUN;
    end

    // Round-robin grant and RAM port mux; data side is the idle default.
    always_comb begin
        if_gnt       = run && if_req && !(d_req && rr_last == SEL_IF);
        d_gnt        = run && d_req && !if_gnt;
        mem_rd_addr  = if_gnt ? mask_addr(if_addr, LOGD) : mask_addr(d_addr, LOGD);
        mem_wr_valid = bl_wr_valid;
        mem_wr_addr  = bl_wr_addr;
        mem_wr_data  = bl_wr_data;
        if (run) begin
            mem_wr_valid = d_gnt && d_we;
            mem_wr_addr  = mask_addr(d_addr, LOGD);
            mem_wr_data  = d_wdata;
        end
    end

    // Remember the last winner; reset to fetch so data takes the first tie.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)  rr_last <= SEL_IF;
        else if (if_gnt) rr_last <= SEL_IF;
        else if (d_gnt)  rr_last <= SEL_D;
    end

    // Registered read return; rdata holds until that port's next read.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt && !d_we;
            if (if_gnt)          if_rdata <= mem_rd_data;
            if (d_gnt && !d_we)  d_rdata  <= mem_rd_data;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequencer and arbiter for the single-port word RAM. It has two phases.
- Boot phase: holds the CPU in reset, assembles UART bytes little-endian into 32-bit words and writes them to RAM at consecutive word addresses.
- Run phase: shares the RAM between the instruction-fetch port and the data load/store port, using round-robin arbitration with registered read return.
It sits between the uart receiver, the CPU core and ram.

Parameters:
LOGD, 10, log2 of RAM depth in words; all RAM addresses are masked to LOGD bits.
BOOT_WORDS, 256, number of words downloaded before the block enters the run phase (1..2^LOGD).

Ports:
clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
rx_valid  in  1  UART byte strobe
rx_data  in  8  UART byte
cpu_reset  out  1  high while booting; holds the CPU in reset
boot_done  out  1  high in run phase
if_req  in  1  instruction fetch request (read only)
if_addr  in  32  fetch word address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid (one cycle after if_gnt)
if_rdata  out  32  fetch data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data word address
d_wdata  in  32  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid (one cycle after d_gnt with d_we=0)
d_rdata  out  32  load data
mem_rd_addr  out  32  to ram rd_addr
mem_rd_data  in  32  from ram rd_data (combinational read)
mem_wr_addr  out  32  to ram wr_addr
mem_wr_data  out  32  to ram wr_data
mem_wr_valid  out  1  to ram wr_valid (synchronous write)

Behaviour:
- States: BOOT, RUN. Reset enters BOOT. An asynchronous reset at any point, including mid-word or mid-boot, clears the byte counter, word counter, partial word, rr_last and all registered outputs immediately.
- Reset values: cpu_reset=1, boot_done=0, if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, mem_wr_valid=0. rr_last is reset to "fetch", so data wins the first tie.
- BOOT:
  - 2-bit byte counter. Bytes 0, 1 and 2 are stored in a 24-bit shift holding register.
  - On the 4th rx_valid: mem_wr_valid=1 for exactly one cycle (registered), mem_wr_data={rx_data, held[23:0]}, mem_wr_addr=word count.
  - The word counter then increments.
  - When a write is issued with word count = BOOT_WORDS-1, the next state is RUN.
  - cpu_reset and boot_done change in the cycle after that last write.
  - if_gnt=d_gnt=0 throughout BOOT.
- RUN:
  - rx_valid is ignored.
  - Grants are combinational from the requests. At most one grant per cycle.
  - Only one requester: that requester is granted.
  - Both requesting: the port not granted most recently wins. rr_last updates on every grant.
  - mem_rd_addr = granted address masked to LOGD bits; zero-extended to 32.
  - Fetch grant, or data grant with d_we=0: mem_rd_data is registered into the port's rdata, and rvalid pulses in the next cycle. rdata holds until the next read on that port.
  - Data grant with d_we=1: mem_wr_valid, mem_wr_addr and mem_wr_data are driven combinationally in the grant cycle (write takes effect at that clk edge). There is no rvalid.
  - A load issued in the cycle after a store to the same address returns the new data.
  - Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle total.
- The address mux is combinational: cycle mux is default data, masked to LOGD bits. This keeps the outputs latch-free and deterministic in idle cycles.

Decomposition:
- Shared package mem_pkg: state encoding (ST_BOOT, ST_RUN) and the port-select constants (SEL_IF, SEL_D).
- Sub-module boot_loader: byte assembly, word counter and the boot-write strobe. It outputs wr_valid/addr/data and a done pulse.
- The top level holds the state register, round-robin arbiter, RAM port mux and read-return registers.

Test Plan:
- BOOT_WORDS=2. Drive bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD → writes of mem[0]=0x44332211 and mem[1]=0xDDCCBBAA. In the next cycle cpu_reset=0 and boot_done=1. In BOOT, if_gnt=0 even with if_req=1.
- Reset mid-word: after bytes 0x01,0x02, assert i_reset_n=0 for 1 cycle, then send 0x11..0x44 → mem[0]=0x44332211. No write occurs before the 4th byte.
- RUN, if_req only, if_addr=1 for 1 cycle → if_gnt=1 that cycle. In the next cycle if_rvalid=1 and if_rdata=0xDDCCBBAA.
- RUN, if_req and d_req both high for 4 cycles (d_we=0, d_addr=0, if_addr=1) → grant order d, if, d, if. rvalids alternate one cycle later with data 0x44332211 and 0xDDCCBBAA respectively.
- Store d_we=1, d_addr=0x405, d_wdata=0xCAFEF00D, then load d_addr=5 in the next cycle → mem_wr_addr=5 during the store. The load returns 0xCAFEF00D, and d_rvalid does not pulse for the store.
- After run phase, send UART bytes → mem_wr_valid stays 0 and RAM contents are unchanged.
